// File: rtl/comparador_pkg.sv
// Shared result codes and FSM encoding for the serial magnitude comparator.
package comparador_pkg;

   localparam logic [2:0] COM_GT   = 3'b001;
   localparam logic [2:0] COM_LT   = 3'b010;
   localparam logic [2:0] COM_EQ   = 3'b100;
   localparam logic [2:0] COM_NONE = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/comparador_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, one-hot gt/lt/eq.
module comparador_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/comparador_serial.sv
// Serial MSB-first comparator, CHUNK bits per cycle, signed or unsigned.
// Define COMPARADOR_EARLY_EXIT_EN to stop at the first differing slice.
import comparador_pkg::*;

module comparador_serial #(
   parameter int W     = 8,
   parameter int CHUNK = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sgn,
   output logic         busy,
   output logic         done,
   output logic [2:0]   com
);

   localparam int N  = W / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t           st;
   logic [IW-1:0]    idx;
   logic [W-1:0]     ra;
   logic [W-1:0]     rb;
   logic [CHUNK-1:0] sla;
   logic [CHUNK-1:0] slb;
   logic             cgt;
   logic             clt;
   logic             ceq;
`ifndef COMPARADOR_EARLY_EXIT_EN
   logic             fnd;
   logic             fgt;
`endif

   // slice idx=0 is the MSB slice
   assign sla = CHUNK'(ra >> (CHUNK * (N - 1 - int'(idx))));
   assign slb = CHUNK'(rb >> (CHUNK * (N - 1 - int'(idx))));

   comparador_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a  (sla),
      .b  (slb),
      .gt (cgt),
      .lt (clt),
      .eq (ceq)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         com  <= COM_NONE;
         idx  <= '0;
         ra   <= '0;
         rb   <= '0;
`ifndef COMPARADOR_EARLY_EXIT_EN
         fnd  <= 1'b0;
         fgt  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (st)
            IDLE, DONE: begin
               if (start) begin
                  // flipping the sign bit maps signed order onto unsigned
                  ra   <= {a[W-1] ^ sgn, a[W-2:0]};
                  rb   <= {b[W-1] ^ sgn, b[W-2:0]};
                  idx  <= '0;
                  st   <= RUN;
                  busy <= 1'b1;
`ifndef COMPARADOR_EARLY_EXIT_EN
                  fnd  <= 1'b0;
                  fgt  <= 1'b0;
`endif
               end else begin
                  st <= IDLE;
               end
            end
            RUN: begin
               idx <= idx + 1'b1;
`ifdef COMPARADOR_EARLY_EXIT_EN
               if (!ceq || idx == LAST) begin
                  st   <= DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                  idx  <= '0;
                  com  <= cgt ? COM_GT : (clt ? COM_LT : COM_EQ);
               end
`else
               if (!fnd && !ceq) begin
                  fnd <= 1'b1;
                  fgt <= cgt;
               end
               if (idx == LAST) begin
                  st   <= DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                  idx  <= '0;
                  if (fnd)
                     com <= fgt ? COM_GT : COM_LT;
                  else
                     com <= cgt ? COM_GT : (clt ? COM_LT : COM_EQ);
               end
`endif
            end
            default: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/comparador_serial.md
COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 Parameter W, 8: operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, 2: bits compared per cycle; W SHALL be an integer multiple of CHUNK; N = W/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a comparison; operands sampled in the accepting cycle.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse; com is valid and updated in this cycle.
REQ-011 com  output  3  one-hot result: 001 means a>b, 010 means a<b, 100 means a==b, 000 means no result since reset.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN and done=1 only in DONE.
REQ-013 start SHALL be accepted in IDLE or DONE; a, b and sgn SHALL be latched; next state is RUN with chunk index 0 (the MSB chunk).
REQ-014 start in RUN SHALL be ignored; latched operands SHALL NOT change.
REQ-015 start in DONE SHALL be accepted: done pulses normally and RUN follows in the next cycle, giving back-to-back operation.
REQ-016 RUN SHALL compare one CHUNK-bit slice per cycle, MSB slice first, as an unsigned compare.
REQ-017 The first differing slice SHALL fix the result: a-slice > b-slice gives 001, otherwise 010.
REQ-018 No differing slice across all N slices SHALL give 100.
REQ-019 With sgn=1, the MSB of each operand SHALL be inverted before slicing, so signed order maps onto unsigned order.
REQ-020 Latency: done SHALL assert exactly N cycles after the accepting edge, unless modified by REQ-027.
REQ-021 After RUN completes, the state SHALL be DONE for exactly one cycle, then IDLE unless start is high.
REQ-022 com SHALL be registered, SHALL change only on entry to DONE, and SHALL hold its value until the next DONE.
REQ-023 Input changes on a, b or sgn after acceptance SHALL have no effect on the running comparison.

Reset
REQ-024 rst=1 at any edge SHALL force: IDLE, busy=0, done=0, com=000, chunk index 0, latched operands 0.
REQ-025 rst SHALL dominate start in the same cycle; a reset mid-RUN SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro COMPARADOR_EARLY_EXIT_EN SHALL select early termination.
REQ-027 When COMPARADOR_EARLY_EXIT_EN is defined: RUN SHALL end in the cycle the first differing slice is found, so done occurs j cycles after acceptance, where j is the 1-based index of that slice. Equal operands SHALL still take N cycles.
REQ-028 When COMPARADOR_EARLY_EXIT_EN is undefined: RUN SHALL always last N cycles, and later slices SHALL NOT alter an already-fixed result.

Structure
REQ-029 Shared package comparador_pkg SHALL hold COM_GT=001, COM_LT=010, COM_EQ=100, COM_NONE=000 and the FSM state encoding.
REQ-030 Sub-module comparador_chunk SHALL be the combinational CHUNK-bit slice comparator, producing one-hot gt/lt/eq; it SHALL be instantiated once.

Verification
All scenarios use W=8, CHUNK=2 (N=4) unless noted.
REQ-031 a=0xA5, b=0x5A, sgn=0, start pulse -> com=001 with done 4 cycles later; with COMPARADOR_EARLY_EXIT_EN, done 1 cycle later.
REQ-032 a=0x3C, b=0x3D, sgn=0 -> com=010 with done at cycle 4 in both configurations; busy high for cycles 1-4.
REQ-033 a=0x80, b=0x01 -> sgn=1 gives com=010; repeated with sgn=0 gives com=001.
REQ-034 a=b=0x77 -> com=100 at cycle 4 in both configurations; com holds 100 through 10 idle cycles.
REQ-035 Restart and reset -> start re-asserted at cycle 2 of a run is ignored; start during done is accepted and the second result follows 4 cycles later; rst asserted at RUN cycle 2 -> next cycle busy=0, done=0, com=000, and no done pulse afterwards.
REQ-036 Parameter set W=5, CHUNK=1 -> a=31, b=30 gives com=001 at cycle 5 (no early exit); a=b=0 gives com=100.
